// File: rtl/rgb_pkg.sv
// Shared types, widths and level/channel helpers for the RGB level controller.
package rgb_pkg;

    localparam int LEVEL_W   = 8;
    localparam int LEVEL_MAX = 255;

    // Selected channel; code 3 is never produced.
    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_e;

    // Shared up/down auto-repeat state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // One saturating step in 9-bit arithmetic so the up sum cannot wrap.
    function automatic logic [LEVEL_W-1:0] step_level(
        input logic [LEVEL_W-1:0] level,
        input logic               up,
        input logic [LEVEL_W-1:0] step
    );
        logic [LEVEL_W:0] sum;
        sum = {1'b0, level} + {1'b0, step};
        if (up) begin
            step_level = (sum > (LEVEL_W+1)'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX) : sum[LEVEL_W-1:0];
        end else begin
            step_level = (level < step) ? '0 : level - step;
        end
    endfunction

    // R -> G -> B -> R.
    function automatic ch_e next_chan(input ch_e chan);
        case (chan)
            CH_R:    next_chan = CH_G;
            CH_G:    next_chan = CH_B;
            default: next_chan = CH_R;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability counter,
// debounced level and a one-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then accept a change only after DEBOUNCE_CYCLES differing samples in a row.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all flops sample pre-edge values; blocking
        // assignments would collapse the synchroniser into a single stage.
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    rise  <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rgb_level_ctrl.sv
// Button-driven RGB brightness controller: three saturating 8-bit levels,
// channel select, and shared up/down auto-repeat.
module rgb_level_ctrl
    import rgb_pkg::*;
#(
    parameter int STEP            = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 4,
    parameter int RESET_LEVEL     = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_sel,
    output logic [LEVEL_W-1:0] RED,
    output logic [LEVEL_W-1:0] GREEN,
    output logic [LEVEL_W-1:0] BLUE,
    output logic [1:0]         chan_sel,
    output logic               at_max,
    output logic               at_min,
    output logic               step_pulse
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic up_lvl, up_rise, down_lvl, down_rise, sel_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .raw(btn_up), .level(up_lvl), .rise(up_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst(rst), .raw(btn_down), .level(down_lvl), .rise(down_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk(clk), .rst(rst), .raw(btn_sel), .level(), .rise(sel_rise)
    );

    rep_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             dir_up, dir_up_next;
    logic             step_req, step_up;
    logic             dir_held, other_held;

    logic [LEVEL_W-1:0] level_q [3];
    logic [LEVEL_W-1:0] sel_level, new_level;
    ch_e                chan_q;
    logic               step_apply;

    // Repeat FSM state, counter and latched direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_up <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            dir_up <= dir_up_next;
        end
    end

    // Repeat FSM next state and step request; leaving DELAY/REPEAT needs a fresh press to re-enter.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves one
        // unassigned, which would otherwise infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        dir_up_next = dir_up;
        step_req    = 1'b0;
        step_up     = dir_up;
        dir_held    = dir_up ? up_lvl : down_lvl;
        other_held  = dir_up ? down_lvl : up_lvl;
        case (state)
            IDLE: begin
                if (up_rise && !down_lvl) begin
                    step_req    = 1'b1;
                    step_up     = 1'b1;
                    dir_up_next = 1'b1;
                    cnt_next    = '0;
                    state_next  = DELAY;
                end else if (down_rise && !up_lvl) begin
                    step_req    = 1'b1;
                    step_up     = 1'b0;
                    dir_up_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = DELAY;
                end
            end
            DELAY: begin
                if (!dir_held || other_held) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                    step_req   = 1'b1;
                    cnt_next   = '0;
                    state_next = REPEAT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!dir_held || other_held) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == CNT_W'(REPEAT_RATE - 1)) begin
                    step_req = 1'b1;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Level of the channel selected before any select update this cycle.
    always_comb begin
        case (chan_q)
            CH_G:    sel_level = level_q[1];
            CH_B:    sel_level = level_q[2];
            default: sel_level = level_q[0];
        endcase
    end

    // A select event in the same cycle swallows the step entirely.
    assign step_apply = step_req && !sel_rise;
    assign new_level  = step_level(sel_level, step_up, LEVEL_W'(STEP));

    // Channel levels, selection and step strobe; only the selected channel moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) level_q[i] <= LEVEL_W'(RESET_LEVEL);
            chan_q     <= CH_R;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step_apply;
            if (step_apply) begin
                case (chan_q)
                    CH_G:    level_q[1] <= new_level;
                    CH_B:    level_q[2] <= new_level;
                    default: level_q[0] <= new_level;
                endcase
            end
            if (sel_rise) chan_q <= next_chan(chan_q);
        end
    end

    assign RED      = level_q[0];
    assign GREEN    = level_q[1];
    assign BLUE     = level_q[2];
    assign chan_sel = chan_q;
    assign at_max   = (sel_level == LEVEL_W'(LEVEL_MAX));
    assign at_min   = (sel_level == '0);

endmodule

// File: tb/tb_rgb_level_ctrl.sv
// Self-checking bench for rgb_level_ctrl: directed scenarios with literal
// expectations plus randomized button activity against a behavioural model.
module tb_rgb_level_ctrl;

    localparam int STEP    = 10;
    localparam int DEB     = 4;
    localparam int RD      = 8;
    localparam int RR      = 4;
    localparam int RST_LVL = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0;
    logic [7:0] RED, GREEN, BLUE;
    logic [1:0] chan_sel;
    logic       at_max, at_min, step_pulse;

    always #5 clk = ~clk;

    rgb_level_ctrl #(
        .STEP(STEP), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .RESET_LEVEL(RST_LVL)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .chan_sel(chan_sel),
        .at_max(at_max), .at_min(at_min), .step_pulse(step_pulse)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buttons: 0 = up, 1 = down, 2 = sel. A button's debounced value flips once the
    // last DEB synchronised samples (taken since its previous flip) all disagree with it.
    // Auto-repeat: steps at hold time 0, RD, RD+RR, RD+2*RR, ...
    int  m_lvl [3];
    int  m_chan;
    bit  m_pulse;
    bit  m_valid = 1'b0;
    bit  s_a [3], s_b [3], deb [3], rise [3];
    bit  hist [3][16];
    int  hlen [3];
    bit  active;
    int  dir;      // 0 = up, 1 = down
    int  held;

    always @(posedge clk) begin : model
        bit raw [3];
        bit step, sel_ev, syn, all_diff;
        raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_sel;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_lvl[i] = RST_LVL;
                s_a[i] = 0; s_b[i] = 0; deb[i] = 0; rise[i] = 0; hlen[i] = 0;
            end
            m_chan = 0; m_pulse = 0; active = 0; dir = 0; held = 0;
            m_valid = 1'b1;
        end else begin
            step = 0;
            if (!active) begin
                if (rise[0] && !deb[1]) begin
                    active = 1; dir = 0; held = 0; step = 1;
                end else if (rise[1] && !deb[0]) begin
                    active = 1; dir = 1; held = 0; step = 1;
                end
            end else if (!deb[dir] || deb[1-dir]) begin
                active = 0;
            end else begin
                held++;
                if (held >= RD && (held - RD) % RR == 0) step = 1;
            end
            sel_ev  = rise[2];
            m_pulse = step && !sel_ev;
            if (m_pulse) begin
                if (dir == 0) m_lvl[m_chan] = (m_lvl[m_chan] + STEP > 255) ? 255 : m_lvl[m_chan] + STEP;
                else          m_lvl[m_chan] = (m_lvl[m_chan] - STEP < 0)   ? 0   : m_lvl[m_chan] - STEP;
            end
            if (sel_ev) m_chan = (m_chan + 1) % 3;
            for (int b = 0; b < 3; b++) begin
                syn = s_b[b]; s_b[b] = s_a[b]; s_a[b] = raw[b];
                for (int k = 15; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = syn;
                if (hlen[b] < 16) hlen[b]++;
                rise[b] = 0;
                all_diff = (hlen[b] >= DEB);
                for (int k = 0; k < DEB; k++) if (hist[b][k] == deb[b]) all_diff = 0;
                if (all_diff) begin
                    deb[b] = !deb[b]; rise[b] = deb[b]; hlen[b] = 0;
                end
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("red",        int'(RED),        m_lvl[0]);
            check("green",      int'(GREEN),      m_lvl[1]);
            check("blue",       int'(BLUE),       m_lvl[2]);
            check("chan_sel",   int'(chan_sel),   m_chan);
            check("step_pulse", int'(step_pulse), int'(m_pulse));
            check("at_max",     int'(at_max),     int'(m_lvl[m_chan] == 255));
            check("at_min",     int'(at_min),     int'(m_lvl[m_chan] == 0));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_up = 0; btn_down = 0; btn_sel = 0;
        edges(2);
        rst = 1'b0;
    endtask

    task automatic press_sel();
        btn_sel = 1; edges(7); btn_sel = 0; edges(15);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 2_000_000);
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset values
        do_reset();
        check("rst_red", int'(RED), 100); check("rst_green", int'(GREEN), 100);
        check("rst_blue", int'(BLUE), 100); check("rst_chan", int'(chan_sel), 0);
        check("rst_atmin", int'(at_min), 0); check("rst_atmax", int'(at_max), 0);
        check("rst_pulse", int'(step_pulse), 0);

        // Single press: level moves exactly 7 edges after the first high sample
        btn_up = 1; edges(6);
        check("press_e6_red", int'(RED), 100);
        btn_up = 0; edges(1);
        check("press_e7_red", int'(RED), 110); check("press_e7_pulse", int'(step_pulse), 1);
        check("model_press", m_lvl[0], 110);
        edges(1);
        check("press_e8_pulse", int'(step_pulse), 0);
        edges(20);
        btn_up = 1; edges(2); btn_up = 0; edges(20);
        check("glitch_red", int'(RED), 110);

        // Hold down from 100 to the floor
        do_reset();
        btn_down = 1; edges(7);
        check("down_first", int'(RED), 90); check("down_first_pulse", int'(step_pulse), 1);
        edges(8);  check("down_delay", int'(RED), 80);
        edges(3);  check("down_gap", int'(RED), 80); check("down_gap_pulse", int'(step_pulse), 0);
        edges(1);  check("down_rate", int'(RED), 70);
        edges(28); check("down_zero", int'(RED), 0); check("down_atmin", int'(at_min), 1);
        check("model_zero", m_lvl[0], 0);
        edges(8);  check("down_floor", int'(RED), 0); check("down_floor_pulse", int'(step_pulse), 1);
        btn_down = 0; edges(20);

        // Saturate up
        do_reset();
        btn_up = 1; edges(67);
        check("up_250", int'(RED), 250); check("up_250_atmax", int'(at_max), 0);
        edges(4);  check("up_255", int'(RED), 255); check("up_atmax", int'(at_max), 1);
        check("model_255", m_lvl[0], 255);
        edges(4);  check("up_hold", int'(RED), 255); check("up_hold_pulse", int'(step_pulse), 1);
        btn_up = 0; edges(20);
        btn_up = 1; edges(7);
        check("up_again", int'(RED), 255); check("up_again_pulse", int'(step_pulse), 1);
        btn_up = 0; edges(20);

        // Select
        do_reset();
        btn_sel = 1; edges(6);
        check("sel_e6", int'(chan_sel), 0);
        btn_sel = 0; edges(1);
        check("sel_e7", int'(chan_sel), 1);
        edges(20);
        btn_up = 1; edges(7);
        check("sel_green", int'(GREEN), 110); check("sel_red", int'(RED), 100);
        check("sel_blue", int'(BLUE), 100);
        btn_up = 0; edges(20);
        press_sel(); check("sel_to2", int'(chan_sel), 2);
        press_sel(); check("sel_wrap", int'(chan_sel), 0);

        // Up and down together: no step
        do_reset();
        btn_up = 1; btn_down = 1; edges(30);
        check("both_red", int'(RED), 100);
        btn_up = 0; btn_down = 0; edges(20);

        // Select and up rising together: step discarded
        do_reset();
        btn_sel = 1; btn_up = 1; edges(6);
        btn_sel = 0; btn_up = 0; edges(1);
        check("selup_chan", int'(chan_sel), 1); check("selup_red", int'(RED), 100);
        check("selup_green", int'(GREEN), 100); check("selup_pulse", int'(step_pulse), 0);
        edges(20);

        // Reset mid-repeat with the button still held
        do_reset();
        btn_up = 1; edges(20);
        check("rr_pre", int'(RED), 130);
        rst = 1; edges(1); rst = 0;
        check("rr_rst_red", int'(RED), 100); check("rr_rst_pulse", int'(step_pulse), 0);
        edges(6); check("rr_e6", int'(RED), 100);
        edges(1); check("rr_e7", int'(RED), 110); check("rr_e7_pulse", int'(step_pulse), 1);
        btn_up = 0; edges(20);

        // Randomized activity, checked every cycle by the model compare
        for (int it = 0; it < 250; it++) begin
            btn_up   = ($urandom_range(0, 2) == 0);
            btn_down = ($urandom_range(0, 3) == 0);
            btn_sel  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1; edges(1); rst = 0;
            end
            edges($urandom_range(1, 40));
        end
        btn_up = 0; btn_down = 0; btn_sel = 0;
        edges(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_level_ctrl.md
Name: rgb_level_ctrl

Overview:
Button-driven brightness controller. It holds the three 8-bit channel levels (RED, GREEN, BLUE) that feed the per-channel pwmgen instances directly downstream. Raw up/down/select push-buttons are synchronised, debounced and edge-detected. Each press steps the selected channel by STEP, saturating at 0 and 255 with no wrap. Holding up or down auto-repeats.

Parameters:
STEP, 10, level change per step event (1..255)
DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a button change (>=1)
REPEAT_DELAY, 8, cycles from the first step to the first auto-repeat step (>=1)
REPEAT_RATE, 4, cycles between auto-repeat steps (>=1)
RESET_LEVEL, 100, level loaded into all channels on reset

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
btn_up  in  1  raw, asynchronous, active-high
btn_down  in  1  raw, asynchronous, active-high
btn_sel  in  1  raw, asynchronous, active-high; cycles the selected channel
RED  out  8  red level to pwmgen
GREEN  out  8  green level to pwmgen
BLUE  out  8  blue level to pwmgen
chan_sel  out  2  selected channel: 0=R, 1=G, 2=B (3 never driven)
at_max  out  1  selected channel == 255
at_min  out  1  selected channel == 0
step_pulse  out  1  one-cycle strobe on every applied step event

Behaviour:
- Reset: rst sampled high at a rising edge gives, after that edge:
  - RED/GREEN/BLUE = RESET_LEVEL, chan_sel = 0, step_pulse = 0.
  - All synchronisers, debounce state and counters cleared; repeat FSM = IDLE.
  - at_min/at_max combinational from the selected level.
  - Reset mid-hold aborts any repeat. A button still held after reset re-debounces and produces a fresh press event.
- Input path, per button:
  - 2-FF synchroniser.
  - Debounce counter increments while the synchronised value differs from the debounced state and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - Rise event = one-cycle pulse on a debounced 0->1 transition.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Latency: a raw press held stable changes the level register DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it high. step_pulse is high in the same cycle the new level appears.
- Repeat FSM (shared up/down), with dir latched on entry:
  - IDLE: on a rise event of exactly one of up/down, emit a step (dir = that button), cnt = 0, go to DELAY. Up and down both debounced-high: no step, stay in IDLE.
  - DELAY: if the dir button is released or the other button is debounced-high, go to IDLE with no step. Else when cnt == REPEAT_DELAY-1, emit a step, cnt = 0, go to REPEAT. Else cnt++.
  - REPEAT: same exit conditions as DELAY. When cnt == REPEAT_RATE-1, emit a step and set cnt = 0. Else cnt++.
  - A released-then-pressed button re-enters via IDLE. A switch from up to down always passes through IDLE.
- Step arithmetic (9-bit internal):
  - up: level = (level > 255-STEP) ? 255 : level+STEP.
  - down: level = (level < STEP) ? 0 : level-STEP.
  - A step at a bound still pulses step_pulse but leaves the level unchanged.
- Select:
  - A sel rise event advances chan_sel 0->1->2->0.
  - A step emitted in the same cycle as a sel event is discarded: no level change, no step_pulse. The FSM still advances its counters.
  - The step target is the channel selected before the sel update.
- Only the selected channel ever changes. Other channels hold their values.

Decomposition:
- Package rgb_pkg:
  - LEVEL_W = 8, LEVEL_MAX = 255.
  - Channel enum CH_R/CH_G/CH_B (2-bit).
  - Repeat FSM state enum IDLE/DELAY/REPEAT.
- Sub-module btn_debounce: synchroniser, debounce counter, debounced level and rise pulse. Parameter DEBOUNCE_CYCLES, ports clk, rst, raw, level, rise. Instantiated three times.

Test Plan:
All scenarios use the default parameters.
- Reset: hold rst 2 cycles -> RED=GREEN=BLUE=100, chan_sel=0, at_min=at_max=0, step_pulse=0.
- Single press: btn_up high 6 cycles -> RED=110 exactly 7 edges after the first sample, with one step_pulse. A 2-cycle btn_up glitch -> no change.
- Hold down from 100:
  - RED goes 90 on the first step, 80 eight cycles later, then steps every 4 cycles to 0.
  - at_min=1 when RED reaches 0; further steps keep RED=0 (never 246).
- Saturate up: RED preset to 250 via steps from reset, then up -> RED=255, at_max=1. Another up -> 255 held, step_pulse still pulses.
- Select:
  - sel press -> chan_sel=1; up press -> GREEN=110 while RED/BLUE stay unchanged.
  - Three sel presses -> chan_sel wraps 2->0.
  - up+down held together -> no step.
  - sel and up rising in the same cycle -> chan_sel advances, no level change.
- Reset mid-repeat: btn_up held in REPEAT, rst pulsed one cycle -> RED=100 after that edge with no step_pulse. With btn_up still held -> next step to 110 after DEBOUNCE_CYCLES+3 edges.
